// File: rtl/seg7_scan_decoder_if.sv
// Display readback bus: the scanned 7-segment inputs plus the decoded-word
// valid/ready output. The master side is the display driver and the consumer;
// the slave side is the decoder.
interface seg7_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [NUM_DIGITS-1:0]   i_an;
    logic [6:0]              i_seg;
    logic                    i_ready;
    logic [4*NUM_DIGITS-1:0] o_value;
    logic                    o_valid;
    logic [NUM_DIGITS-1:0]   o_digit_err;
    logic                    o_overrun;
    logic                    o_scan_err;

    modport master (
        output i_an, i_seg, i_ready,
        input  o_value, o_valid, o_digit_err, o_overrun, o_scan_err
    );

    modport slave (
        input  i_an, i_seg, i_ready,
        output o_value, o_valid, o_digit_err, o_overrun, o_scan_err
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers the hex word shown on a time-multiplexed active-low 7-segment bus.
// Each digit must hold one pattern for STABLE_CYCLES samples before it is
// captured; once all digits are seen the word is offered on valid/ready.

// Per-digit capture slot: shadow nibble, seen bit and invalid-pattern flag.
module seg7_digit_slot (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       cap,
    input  logic       commit,
    input  logic [3:0] nib,
    input  logic       inval,
    output logic [3:0] shadow,
    output logic       seen,
    output logic       err
);
    // Commit clears the frame bookkeeping; a capture on the same edge lands
    // afterwards so it belongs to the next frame. Shadow survives commits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow <= 4'h0;
            seen   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (commit) begin
                seen <= 1'b0;
                err  <= 1'b0;
            end
            if (cap) begin
                shadow <= nib;
                seen   <= 1'b1;
                err    <= inval;
            end
        end
    end
endmodule

module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input logic                i_clk,
    input logic                i_rst,
    seg7_scan_decoder_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    // Inverse of the hex encoder; unknown patterns give {invalid, 0}.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = {1'b0, 4'h0};
            7'b1111001: r = {1'b0, 4'h1};
            7'b0100100: r = {1'b0, 4'h2};
            7'b0110000: r = {1'b0, 4'h3};
            7'b0011001: r = {1'b0, 4'h4};
            7'b0010010: r = {1'b0, 4'h5};
            7'b0000010: r = {1'b0, 4'h6};
            7'b1111000: r = {1'b0, 4'h7};
            7'b0000000: r = {1'b0, 4'h8};
            7'b0010000: r = {1'b0, 4'h9};
            7'b0001000: r = {1'b0, 4'hA};
            7'b0000011: r = {1'b0, 4'hB};
            7'b1000110: r = {1'b0, 4'hC};
            7'b0100001: r = {1'b0, 4'hD};
            7'b0000110: r = {1'b0, 4'hE};
            7'b0001110: r = {1'b0, 4'hF};
            default:    r = {1'b1, 4'h0};
        endcase
        return r;
    endfunction

    logic [KW-1:0]                samp_k;
    logic                         active;
    logic                         multi;
    logic                         last_act;
    logic [KW-1:0]                last_k;
    logic [6:0]                   last_seg;
    logic [CW-1:0]                cnt;
    logic [CW-1:0]                cnt_next;
    logic                         same;
    logic                         capture;
    logic [4:0]                   dec;
    logic [NUM_DIGITS-1:0]        cap_vec;
    logic [NUM_DIGITS-1:0][3:0]   shadow;
    logic [NUM_DIGITS-1:0]        seen;
    logic [NUM_DIGITS-1:0]        err_acc;
    logic                         commit;

    // Classify the sample: exactly one low enable is active, anything else idle.
    always_comb begin
        int nlow;
        nlow   = 0;
        samp_k = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!bus.i_an[i]) begin
                nlow   = nlow + 1;
                samp_k = KW'(i);
            end
        end
        active = (nlow == 1);
        multi  = (nlow > 1);
    end

    // Stability count and single-shot capture per stable run.
    always_comb begin
        same = active && last_act && (last_k == samp_k) && (last_seg == bus.i_seg);
        if (!active)
            cnt_next = '0;
        else if (same)
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        else
            cnt_next = CW'(1);
        // Saturated-and-held runs do not fire again.
        capture = active && (cnt_next == CNT_MAX) && !(same && (cnt == CNT_MAX));
        dec     = decode(bus.i_seg);
        commit  = &seen;
    end

    // Remember last sample and the run length.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_act <= 1'b0;
            last_k   <= '0;
            last_seg <= '0;
            cnt      <= '0;
        end else begin
            last_act <= active;
            last_k   <= samp_k;
            last_seg <= bus.i_seg;
            cnt      <= cnt_next;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
        assign cap_vec[g] = capture && (samp_k == KW'(g));
        seg7_digit_slot u_slot (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .cap    (cap_vec[g]),
            .commit (commit),
            .nib    (dec[3:0]),
            .inval  (dec[4]),
            .shadow (shadow[g]),
            .seen   (seen[g]),
            .err    (err_acc[g])
        );
    end

    // Output slot: commit a full frame if free, else drop it and flag overrun.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_value     <= '0;
            bus.o_valid     <= 1'b0;
            bus.o_digit_err <= '0;
            bus.o_overrun   <= 1'b0;
            bus.o_scan_err  <= 1'b0;
        end else begin
            bus.o_overrun <= 1'b0;
            if (commit) begin
                if (!bus.o_valid || bus.i_ready) begin
                    bus.o_value     <= shadow;
                    bus.o_digit_err <= err_acc;
                    bus.o_valid     <= 1'b1;
                end else begin
                    bus.o_overrun <= 1'b1;
                end
            end else if (bus.o_valid && bus.i_ready) begin
                bus.o_valid <= 1'b0;
            end
            if (multi)
                bus.o_scan_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (4 digits, 4-sample debounce).
module tb_seg7_scan_decoder;
    logic i_clk = 1'b0;
    logic i_rst;
    int   n_cmp = 0;
    int   n_err = 0;

    seg7_scan_decoder_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic show_raw(input int k, input logic [6:0] s, input int n);
        bus.i_an    = 4'hF;
        bus.i_an[k] = 1'b0;
        bus.i_seg   = s;
        repeat (n) step();
    endtask

    task automatic show(input int k, input logic [3:0] d, input int n);
        show_raw(k, enc(d), n);
    endtask

    task automatic blank(input int n);
        bus.i_an = 4'hF;
        repeat (n) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        bus.i_an = 4'hF;
        bus.i_seg = 7'h7F;
        bus.i_ready = 1'b1;
        repeat (3) step();
        i_rst = 1'b0;
        chk("rst_value", bus.o_value, 0);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_derr", bus.o_digit_err, 0);
        chk("rst_ovr", bus.o_overrun, 0);
        chk("rst_scan", bus.o_scan_err, 0);

        // Basic frame 3, A, 0, F
        show(0, 4'h3, 6);
        show(1, 4'hA, 6);
        show(2, 4'h0, 6);
        show(3, 4'hF, 4);
        chk("basic_valid_early", bus.o_valid, 0);
        step();
        chk("basic_valid", bus.o_valid, 1);
        chk("basic_value", bus.o_value, 32'hF0A3);
        chk("basic_derr", bus.o_digit_err, 0);
        step();
        chk("basic_valid_fall", bus.o_valid, 0);

        // Debounce: short A run, then B; blank splits digit 2's run
        show(0, 4'h5, 6);
        show(1, 4'hA, 3);
        show(1, 4'hB, 4);
        show(2, 4'h7, 3);
        blank(1);
        show(2, 4'h7, 3);
        show(3, 4'h8, 6);
        chk("deb_incomplete", bus.o_valid, 0);
        show(2, 4'h7, 5);
        chk("deb_valid", bus.o_valid, 1);
        chk("deb_value", bus.o_value, 32'h87B5);
        chk("deb_derr", bus.o_digit_err, 0);
        step();
        chk("deb_valid_fall", bus.o_valid, 0);

        // Invalid pattern on digit 2
        show(0, 4'h1, 6);
        show(1, 4'h2, 6);
        show_raw(2, 7'b1111111, 6);
        show(3, 4'h4, 5);
        chk("inv_valid", bus.o_valid, 1);
        chk("inv_value", bus.o_value, 32'h4021);
        chk("inv_derr", bus.o_digit_err, 32'b0100);
        step();
        chk("inv_valid_fall", bus.o_valid, 0);

        // Backpressure and overrun
        bus.i_ready = 1'b0;
        show(0, 4'h4, 6);
        show(1, 4'h3, 6);
        show(2, 4'h2, 6);
        show(3, 4'h1, 5);
        chk("bp_valid", bus.o_valid, 1);
        chk("bp_value", bus.o_value, 32'h1234);
        chk("bp_ovr_idle", bus.o_overrun, 0);
        show(0, 4'h8, 6);
        show(1, 4'h7, 6);
        show(2, 4'h6, 6);
        show(3, 4'h5, 5);
        chk("ovr_pulse", bus.o_overrun, 1);
        chk("ovr_value_held", bus.o_value, 32'h1234);
        chk("ovr_valid_held", bus.o_valid, 1);
        step();
        chk("ovr_pulse_end", bus.o_overrun, 0);
        chk("ovr_value_held2", bus.o_value, 32'h1234);
        bus.i_ready = 1'b1;
        step();
        chk("bp_xfer_fall", bus.o_valid, 0);
        show(0, 4'hC, 6);
        show(1, 4'hB, 6);
        show(2, 4'hA, 6);
        show(3, 4'h9, 5);
        chk("third_valid", bus.o_valid, 1);
        chk("third_value", bus.o_value, 32'h9ABC);
        step();
        chk("third_fall", bus.o_valid, 0);

        // Scan error: multi-hot enables never capture
        show(0, 4'h3, 6);
        show(1, 4'h3, 6);
        show(2, 4'h3, 6);
        bus.i_an = 4'b0011;
        bus.i_seg = enc(4'h8);
        repeat (5) step();
        chk("scan_err_set", bus.o_scan_err, 1);
        chk("scan_no_capture", bus.o_valid, 0);
        blank(2);
        chk("scan_err_sticky", bus.o_scan_err, 1);

        // Reset mid-frame, then a clean frame with no stale digits
        show(0, 4'h3, 6);
        show(1, 4'h3, 6);
        bus.i_an = 4'hF;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("rst2_value", bus.o_value, 0);
        chk("rst2_valid", bus.o_valid, 0);
        chk("rst2_derr", bus.o_digit_err, 0);
        chk("rst2_ovr", bus.o_overrun, 0);
        chk("rst2_scan", bus.o_scan_err, 0);
        show(2, 4'hD, 6);
        show(3, 4'hC, 6);
        chk("rst2_no_stale", bus.o_valid, 0);
        show(0, 4'hF, 6);
        show(1, 4'hE, 5);
        chk("rst2_valid_frame", bus.o_valid, 1);
        chk("rst2_value_frame", bus.o_value, 32'hCDEF);
        chk("rst2_derr_frame", bus.o_digit_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
